// File: rtl/bcd_clock.sv
// bcd_clock: HH:MM (24-hour) packed-BCD "plus one minute" incrementer.
// The controller presents the current time on the input digits and raises
// add_one; on the first clock edge that sees add_one high after it was low,
// the input time plus one minute is registered onto the out_* digits.
// The result depends only on the inputs sampled at that edge, never on the
// previously registered output.
module bcd_clock (
    input  logic       clk,
    input  logic       reset,
    input  logic       add_one,
    input  logic [3:0] ms_hour,
    input  logic [3:0] ls_hour,
    input  logic [3:0] ms_min,
    input  logic [3:0] ls_min,
    output logic [3:0] out_ms_hour,
    output logic [3:0] out_ls_hour,
    output logic [3:0] out_ms_min,
    output logic [3:0] out_ls_min,
    output logic       day_wrap
);

    logic       r_add_prev;
    logic       w_fire;
    logic [3:0] w_ms_hour;
    logic [3:0] w_ls_hour;
    logic [3:0] w_ms_min;
    logic [3:0] w_ls_min;
    logic       w_wrap;

    // A request fires only on the low-to-high transition of add_one.
    assign w_fire = add_one & ~r_add_prev;

    // Ripple-carry increment of the input time. The ">=" tests fold
    // out-of-range digits into a carry so no digit ever wraps through 15->0.
    always_comb begin
        w_ms_hour = ms_hour;
        w_ls_hour = ls_hour;
        w_ms_min  = ms_min;
        w_ls_min  = ls_min;
        w_wrap    = 1'b0;
        if (ls_min >= 4'd9) begin
            w_ls_min = 4'd0;
            if (ms_min >= 4'd5) begin
                w_ms_min = 4'd0;
                if ((ms_hour > 4'd2) || ((ms_hour == 4'd2) && (ls_hour >= 4'd3))) begin
                    w_ms_hour = 4'd0;
                    w_ls_hour = 4'd0;
                    w_wrap    = 1'b1;
                end else if (ls_hour >= 4'd9) begin
                    w_ls_hour = 4'd0;
                    w_ms_hour = ms_hour + 4'd1;
                end else begin
                    w_ls_hour = ls_hour + 4'd1;
                end
            end else begin
                w_ms_min = ms_min + 4'd1;
            end
        end else begin
            w_ls_min = ls_min + 4'd1;
        end
    end

    // Edge-detect history, result capture on a firing edge, one-cycle wrap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_add_prev  <= 1'b0;
            out_ms_hour <= 4'd0;
            out_ls_hour <= 4'd0;
            out_ms_min  <= 4'd0;
            out_ls_min  <= 4'd0;
            day_wrap    <= 1'b0;
        end else begin
            r_add_prev <= add_one;
            if (w_fire) begin
                out_ms_hour <= w_ms_hour;
                out_ls_hour <= w_ls_hour;
                out_ms_min  <= w_ms_min;
                out_ls_min  <= w_ls_min;
                day_wrap    <= w_wrap;
            end else begin
                day_wrap    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_clock.sv
// tb_bcd_clock: directed checks of the BCD plus-one-minute incrementer.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_bcd_clock;

    logic       clk;
    logic       reset;
    logic       add_one;
    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
    logic [3:0] out_ms_hour;
    logic [3:0] out_ls_hour;
    logic [3:0] out_ms_min;
    logic [3:0] out_ls_min;
    logic       day_wrap;

    int total;
    int bad;

    logic [15:0] out_t;
    assign out_t = {out_ms_hour, out_ls_hour, out_ms_min, out_ls_min};

    bcd_clock dut (
        .clk         (clk),
        .reset       (reset),
        .add_one     (add_one),
        .ms_hour     (ms_hour),
        .ls_hour     (ls_hour),
        .ms_min      (ms_min),
        .ls_min      (ls_min),
        .out_ms_hour (out_ms_hour),
        .out_ls_hour (out_ls_hour),
        .out_ms_min  (out_ms_min),
        .out_ls_min  (out_ls_min),
        .day_wrap    (day_wrap)
    );

    // clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic set_time(input logic [15:0] t);
        {ms_hour, ls_hour, ms_min, ls_min} = t;
    endtask

    // One full request: present t, raise add_one for one clock, lower it.
    // Returns at the falling edge right after the firing rising edge.
    task automatic do_pulse(input logic [15:0] t);
        @(negedge clk);
        set_time(t);
        add_one = 1'b1;
        @(negedge clk);
        add_one = 1'b0;
    endtask

    // Reference model via minutes-of-day arithmetic (legal inputs only).
    function automatic logic [15:0] next_bcd(input logic [15:0] t);
        int h, m, tot;
        h = int'(t[15:12]) * 10 + int'(t[11:8]);
        m = int'(t[7:4]) * 10 + int'(t[3:0]);
        tot = (h * 60 + m + 1) % 1440;
        h = tot / 60;
        m = tot % 60;
        next_bcd = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic test_reset;
        reset   = 1'b1;
        add_one = 1'b0;
        set_time(16'h1234);
        repeat (3) @(negedge clk);
        total++;
        if (out_t !== 16'h0000) begin
            bad++;
            $display("FAIL reset_time: got %h want 0000", out_t);
        end
        total++;
        if (day_wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_wrap: got %b want 0", day_wrap);
        end
        reset = 1'b0;
        set_time(16'h0001);
        add_one = 1'b1;
        @(negedge clk);
        total++;
        if (out_t !== 16'h0002) begin
            bad++;
            $display("FAIL long_pulse_first: got %h want 0002", out_t);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            total++;
            if (out_t !== 16'h0002 || day_wrap !== 1'b0) begin
                bad++;
                $display("FAIL long_pulse_hold cycle %0d: got %h wrap %b want 0002 wrap 0",
                         i, out_t, day_wrap);
            end
        end
        add_one = 1'b0;
    endtask

    task automatic test_steps;
        logic [15:0] vin [0:8];
        logic [15:0] vexp[0:8];
        vin[0] = 16'h1111; vexp[0] = 16'h1112;
        vin[1] = 16'h1234; vexp[1] = 16'h1235;
        vin[2] = 16'h1259; vexp[2] = 16'h1300;
        vin[3] = 16'h0159; vexp[3] = 16'h0200;
        vin[4] = 16'h1959; vexp[4] = 16'h2000;
        vin[5] = 16'h2059; vexp[5] = 16'h2100;
        vin[6] = 16'h2029; vexp[6] = 16'h2030;
        vin[7] = 16'h0900; vexp[7] = 16'h0901;
        vin[8] = 16'h1900; vexp[8] = 16'h1901;
        for (int i = 0; i < 9; i++) begin
            do_pulse(vin[i]);
            total++;
            if (out_t !== vexp[i] || day_wrap !== 1'b0) begin
                bad++;
                $display("FAIL step %h: got %h wrap %b want %h wrap 0",
                         vin[i], out_t, day_wrap, vexp[i]);
            end
        end
    endtask

    task automatic test_midnight;
        do_pulse(16'h2358);
        total++;
        if (out_t !== 16'h2359 || day_wrap !== 1'b0) begin
            bad++;
            $display("FAIL step 2358: got %h wrap %b want 2359 wrap 0", out_t, day_wrap);
        end
        do_pulse(16'h2359);
        total++;
        if (out_t !== 16'h0000 || day_wrap !== 1'b1) begin
            bad++;
            $display("FAIL midnight: got %h wrap %b want 0000 wrap 1", out_t, day_wrap);
        end
        @(negedge clk);
        total++;
        if (out_t !== 16'h0000 || day_wrap !== 1'b0) begin
            bad++;
            $display("FAIL midnight_after: got %h wrap %b want 0000 wrap 0", out_t, day_wrap);
        end
    endtask

    task automatic test_full_day;
        logic [15:0] t;
        logic [15:0] e;
        int wraps;
        int step_bad;
        t = 16'h0001;
        wraps = 0;
        step_bad = 0;
        for (int i = 0; i < 1440; i++) begin
            e = next_bcd(t);
            do_pulse(t);
            if (day_wrap === 1'b1) wraps++;
            if (out_t !== e || (day_wrap !== (e == 16'h0000))) begin
                step_bad++;
                if (step_bad <= 5)
                    $display("FAIL day_step %0d from %h: got %h wrap %b want %h",
                             i, t, out_t, day_wrap, e);
            end
            if ({out_ms_hour, out_ls_hour} > 8'h23 || out_ls_hour > 4'd9 ||
                out_ms_min > 4'd5 || out_ls_min > 4'd9) begin
                step_bad++;
                if (step_bad <= 5)
                    $display("FAIL day_range %0d: got %h want legal time", i, out_t);
            end
            t = out_t;
        end
        total++;
        if (step_bad != 0) begin
            bad++;
            $display("FAIL full_day_steps: got %0d bad steps want 0", step_bad);
        end
        total++;
        if (t !== 16'h0001) begin
            bad++;
            $display("FAIL full_day_end: got %h want 0001", t);
        end
        total++;
        if (wraps != 1) begin
            bad++;
            $display("FAIL full_day_wraps: got %0d want 1", wraps);
        end
    endtask

    task automatic test_robust;
        // Asynchronous reset mid-pulse.
        do_pulse(16'h1234);
        total++;
        if (out_t !== 16'h1235) begin
            bad++;
            $display("FAIL pre_reset: got %h want 1235", out_t);
        end
        @(negedge clk);
        set_time(16'h0530);
        add_one = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_t !== 16'h0000 || day_wrap !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got %h wrap %b want 0000 wrap 0", out_t, day_wrap);
        end
        // add_one still high across reset release: one increment after release.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (out_t !== 16'h0531) begin
            bad++;
            $display("FAIL release_fire: got %h want 0531", out_t);
        end
        // Inputs change while add_one stays high: no second increment.
        set_time(16'h0700);
        repeat (2) @(negedge clk);
        set_time(16'h1818);
        @(negedge clk);
        total++;
        if (out_t !== 16'h0531) begin
            bad++;
            $display("FAIL no_refire: got %h want 0531", out_t);
        end
        add_one = 1'b0;
        // Out-of-range input folds into a day wrap.
        do_pulse(16'h2FFF);
        total++;
        if (out_t !== 16'h0000 || day_wrap !== 1'b1) begin
            bad++;
            $display("FAIL oor_2FFF: got %h wrap %b want 0000 wrap 1", out_t, day_wrap);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        add_one = 1'b0;
        set_time(16'h0000);
        test_reset();
        test_steps();
        test_midnight();
        test_full_day();
        test_robust();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_clock.md
Name: bcd_clock

Overview:
- Hours/minutes BCD time-of-day incrementer with four packed BCD digits (HH:MM, 24-hour format).
- On each rising edge of the add_one request, registers the presented input time plus one minute, computed with ripple carry across the digits, and holds it on the outputs.
- Sits beside a time-keeping register or controller: the controller presents the current time, pulses add_one, and reads the next time back.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- add_one  input  1  increment request; level signal, acted on at its 0->1 transition only
- ms_hour  input  4  tens-of-hours BCD digit, valid 0..2
- ls_hour  input  4  units-of-hours BCD digit, valid 0..9 (0..3 when ms_hour=2)
- ms_min  input  4  tens-of-minutes BCD digit, valid 0..5
- ls_min  input  4  units-of-minutes BCD digit, valid 0..9
- out_ms_hour  output  4  registered tens-of-hours of the result
- out_ls_hour  output  4  registered units-of-hours of the result
- out_ms_min  output  4  registered tens-of-minutes of the result
- out_ls_min  output  4  registered units-of-minutes of the result
- day_wrap  output  1  registered one-cycle pulse when the increment rolled 23:59 to 00:00

Behaviour:
- Reset (asynchronous, active-high): all out_* digits = 0, day_wrap = 0, internal add_prev = 0.
- Edge detect: add_prev <= add_one every clock. An increment fires on a clock edge where add_one=1 and add_prev=0.
  - Exactly one increment per request, however long add_one stays high.
  - add_one held high across reset release fires one increment on the first clock after release.
- Latency: outputs reflect the new value at the first rising clk edge at which add_one is seen high after being low.
  - The increment uses the input digits sampled at that same edge.
  - Inputs changing while no increment fires have no effect on the outputs.
- Hold: with no increment firing, all out_* hold their value and day_wrap = 0.
- Increment ripple, combinational from the inputs:
  - ls_min >= 9: out_ls_min = 0, carry into the minutes tens; else out_ls_min = ls_min+1 and all higher digits pass through.
  - On minutes carry, ms_min >= 5: out_ms_min = 0, carry into the hours; else out_ms_min = ms_min+1 and the hours pass through.
  - On hours carry, hour is 23 or above (ms_hour > 2, or ms_hour = 2 and ls_hour >= 3): both hour digits = 0 and day_wrap = 1 for that cycle.
  - On hours carry otherwise, ls_hour >= 9: out_ls_hour = 0, out_ms_hour = ms_hour+1; else out_ls_hour = ls_hour+1 and out_ms_hour = ms_hour.
- Out-of-range input digits are handled by the ">=" comparisons above. The result is always a legal time 00:00..23:59, except that an out-of-range digit not reached by the carry passes through unchanged.
- Only 4-bit arithmetic is used; no digit wraps through binary 15->0.
- The result must not depend on any internal time state: the output is always the input plus one.

Test Plan:
- Reset: assert reset with add_one=0 -> outputs 00:00, day_wrap=0. Release it, present 00:01, pulse add_one high for 8 clocks -> 00:02 after one clock, then unchanged for the remaining 7 cycles.
- Simple steps: 11:11 -> 11:12; 12:34 -> 12:35.
- Minute and hour carries: 12:59 -> 13:00; 01:59 -> 02:00; 19:59 -> 20:00; 20:59 -> 21:00; 20:29 -> 20:30. Also 09:00 -> 09:01 and 19:00 -> 19:01.
- Midnight: 23:59 -> 00:00 with day_wrap=1 for exactly one cycle; also 23:58 -> 23:59 with day_wrap=0.
- Full day: start at 00:01 and feed each output back as the next input for 1440 pulses. Every step must be +1 minute, the hour never exceeds 23, the minutes never exceed 59, it ends at 00:01, and day_wrap pulses exactly once.
- Robustness:
  - Assert reset mid-pulse -> outputs clear immediately, without waiting for clk.
  - Change the inputs while add_one stays high -> no second increment.
  - Input 2F:FF -> 00:00 with day_wrap=1.
